// File: rtl/complete_stage_if.sv
// complete_stage_if: FU result inputs and dual writeback outputs of the completion stage
interface complete_stage_if;
  logic [2:0]       fu_valid;
  logic [2:0][3:0]  fu_rob;
  logic [2:0][5:0]  fu_rd;
  logic [2:0]       fu_regwrite;
  logic [2:0][31:0] fu_data;
  logic [2:0]       fu_ready;
  logic             wb0_valid;
  logic [3:0]       wb0_rob;
  logic [5:0]       wb0_rd;
  logic             wb0_regwrite;
  logic [31:0]      wb0_data;
  logic             wb1_valid;
  logic [3:0]       wb1_rob;
  logic [5:0]       wb1_rd;
  logic             wb1_regwrite;
  logic [31:0]      wb1_data;
  logic [63:0]      phy_rdy_set;
  logic [15:0]      rob_done;
  logic [2:0]       buf_count;
  modport master (
    output fu_valid, fu_rob, fu_rd, fu_regwrite, fu_data,
    input  fu_ready, wb0_valid, wb0_rob, wb0_rd, wb0_regwrite, wb0_data,
    input  wb1_valid, wb1_rob, wb1_rd, wb1_regwrite, wb1_data,
    input  phy_rdy_set, rob_done, buf_count
  );
  modport slave (
    input  fu_valid, fu_rob, fu_rd, fu_regwrite, fu_data,
    output fu_ready, wb0_valid, wb0_rob, wb0_rd, wb0_regwrite, wb0_data,
    output wb1_valid, wb1_rob, wb1_rd, wb1_regwrite, wb1_data,
    output phy_rdy_set, rob_done, buf_count
  );
endinterface

// File: rtl/complete_stage.sv
// complete_stage: merges up to three FU results into two writeback slots, spilling
// the excess into a 4-entry in-order overflow FIFO that always drains first.
module complete_stage (
  input logic clk,
  input logic reset,
  complete_stage_if.slave bus
);
  typedef struct packed {
    logic [3:0]  rob;
    logic [5:0]  rd;
    logic        rw;
    logic [31:0] data;
  } ent_t;
  ent_t mem [4];
  ent_t af [3];
  ent_t c0, c1;
  logic [2:0] cnt, cnt_n, base;
  logic [1:0] rd_p, wr_p, drf, n;
  logic [2:0] acc, wen;
  logic [1:0] widx [3];
  logic [3:0] tot;
  logic v0, v1;
  logic [63:0] phy_n;
  logic [15:0] done_n;
  assign bus.fu_ready = {3{cnt <= 3'd3 && !reset}};
  assign bus.buf_count = cnt;
  always_comb begin
    acc = bus.fu_valid & bus.fu_ready;
    n = '0;
    for (int i = 0; i < 3; i++) af[i] = '0;
    for (int i = 0; i < 3; i++)
      if (acc[i]) begin
        af[n] = {bus.fu_rob[i], bus.fu_rd[i], bus.fu_regwrite[i], bus.fu_data[i]};
        n = n + 2'd1;
      end
    tot = 4'(cnt) + 4'(n);
    v0 = tot != 4'd0;
    v1 = tot >= 4'd2;
    c0 = !v0 ? '0 : cnt != 3'd0 ? mem[rd_p] : af[0];
    c1 = !v1 ? '0 : cnt >= 3'd2 ? mem[rd_p + 2'd1] : cnt == 3'd1 ? af[0] : af[1];
    drf = cnt >= 3'd2 ? 2'd2 : cnt[1:0];
    // accepted FU results past the two writeback slots land right behind the surviving FIFO entries
    base = cnt > 3'd2 ? cnt : 3'd2;
    for (int j = 0; j < 3; j++) begin
      wen[j] = 2'(j) < n && (cnt + 3'(j)) >= 3'd2;
      widx[j] = wr_p + 2'(cnt + 3'(j) - base);
    end
    cnt_n = 3'(tot - (v1 ? 4'd2 : 4'(v0)));
    phy_n = '0;
    done_n = '0;
    if (v0) begin
      done_n[c0.rob] = 1'b1;
      if (c0.rw && c0.rd != 6'd0) phy_n[c0.rd] = 1'b1;
    end
    if (v1) begin
      done_n[c1.rob] = 1'b1;
      if (c1.rw && c1.rd != 6'd0) phy_n[c1.rd] = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wen[0]) mem[widx[0]] <= af[0];
    if (wen[1]) mem[widx[1]] <= af[1];
    if (wen[2]) mem[widx[2]] <= af[2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rd_p <= '0;
      wr_p <= '0;
      bus.wb0_valid <= 1'b0;
      {bus.wb0_rob, bus.wb0_rd, bus.wb0_regwrite, bus.wb0_data} <= '0;
      bus.wb1_valid <= 1'b0;
      {bus.wb1_rob, bus.wb1_rd, bus.wb1_regwrite, bus.wb1_data} <= '0;
      bus.phy_rdy_set <= '0;
      bus.rob_done <= '0;
    end else begin
      cnt <= cnt_n;
      rd_p <= rd_p + drf;
      wr_p <= wr_p + 2'(cnt_n - cnt + 3'(drf));
      bus.wb0_valid <= v0;
      {bus.wb0_rob, bus.wb0_rd, bus.wb0_regwrite, bus.wb0_data} <= c0;
      bus.wb1_valid <= v1;
      {bus.wb1_rob, bus.wb1_rd, bus.wb1_regwrite, bus.wb1_data} <= c1;
      bus.phy_rdy_set <= phy_n;
      bus.rob_done <= done_n;
    end
  end
endmodule
